key_move_ctrl: RTL and testbench

//  Upstream stage of the player-craft block. Turns four raw push-button inputs into the move_en/direct stream that the craft block consumes.
//  - Synchronises and debounces each key.
//  - Arbitrates by fixed priority.
//  - Emits a single-cycle move pulse on press, then auto-repeat pulses while the key is held.

---
 rtl/key_move_ctrl_pkg.sv | 24 ++
 rtl/key_move_ctrl_if.sv | 24 ++
 rtl/key_move_ctrl_debounce.sv | 38 +++
 rtl/key_move_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_move_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_move_ctrl_pkg.sv
// Shared codes for the key-to-move front end: direction codes, FSM states
// and default timing constants.
package key_move_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        KEY_ST_IDLE   = 2'd0,
        KEY_ST_FIRST  = 2'd1,
        KEY_ST_HOLD   = 2'd2,
        KEY_ST_REPEAT = 2'd3
    } key_state_e;

    localparam int KEY_DEBOUNCE_CYCLES = 50000;
    localparam int KEY_HOLD_DELAY      = 2000000;
    localparam int KEY_REPEAT_PERIOD   = 100000;
    localparam int KEY_ACCEL_AFTER     = 32;

endpackage

// File: rtl/key_move_ctrl_if.sv
// Key pins in, move strobe and direction out. The design uses the slave side,
// the key board / stimulus side uses master.
interface key_move_ctrl_if;
    import key_move_ctrl_pkg::*;

    logic en_i;
    logic key_up_i;
    logic key_down_i;
    logic key_left_i;
    logic key_right_i;
    logic move_en_o;
    dir_e direct_o;

    modport master (
        output en_i, key_up_i, key_down_i, key_left_i, key_right_i,
        input  move_en_o, direct_o
    );

    modport slave (
        input  en_i, key_up_i, key_down_i, key_left_i, key_right_i,
        output move_en_o, direct_o
    );

endinterface

// File: rtl/key_move_ctrl_debounce.sv
// One key: 2-flop synchroniser followed by a debounce counter that only lets
// a level through after it has been stable for DEBOUNCE_CYCLES cycles.
module key_debounce
    import key_move_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_move_ctrl.sv
// Four debounced keys -> fixed-priority direction -> press/hold/auto-repeat
// move strobe. Define KEY_ACCEL_EN to halve the repeat period after ACCEL_AFTER repeats.
module key_move_ctrl
    import key_move_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int HOLD_DELAY      = KEY_HOLD_DELAY,
    parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD,
    parameter int ACCEL_AFTER     = KEY_ACCEL_AFTER
) (
    input  logic            clk_run,
    input  logic            rst,
    key_move_ctrl_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || HOLD_DELAY < 2 || REPEAT_PERIOD < 4 || ACCEL_AFTER < 1) begin : g_bad_params
        $error("key_move_ctrl: timing parameter out of range");
    end

    localparam int MAX_T = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int TW    = $clog2(MAX_T);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_DELAY - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_PERIOD - 1);

    logic [3:0]    raw;
    logic [3:0]    deb;
    logic          any_key;
    dir_e          sel_dir;
    dir_e          cur_dir;
    key_state_e    state;
    logic [TW-1:0] timer;
    logic [TW-1:0] rep_last;
    logic          move_en;
    dir_e          direct;

    assign raw = {bus.key_right_i, bus.key_left_i, bus.key_down_i, bus.key_up_i};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk (clk_run),
            .rst (rst),
            .raw (raw[i]),
            .deb (deb[i])
        );
    end

    always_comb begin
        any_key = |deb;
        sel_dir = DIR_UP;
        if      (deb[0]) sel_dir = DIR_UP;
        else if (deb[1]) sel_dir = DIR_DOWN;
        else if (deb[2]) sel_dir = DIR_LEFT;
        else if (deb[3]) sel_dir = DIR_RIGHT;
    end

`ifdef KEY_ACCEL_EN
    localparam int RW = $clog2(ACCEL_AFTER + 1);
    localparam logic [RW-1:0] RCNT_SAT  = RW'(ACCEL_AFTER);
    localparam logic [TW-1:0] FAST_LAST = TW'((REPEAT_PERIOD >> 1) - 1);

    logic [RW-1:0] rep_cnt;
    logic          fast;
    logic          rep_keep;

    assign rep_keep = bus.en_i && (state == KEY_ST_REPEAT) && any_key && (sel_dir == cur_dir);
    assign rep_last = fast ? FAST_LAST : REP_LAST;
`else
    assign rep_last = REP_LAST;
`endif

    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state   <= KEY_ST_IDLE;
            timer   <= '0;
            cur_dir <= DIR_UP;
            move_en <= 1'b0;
            direct  <= DIR_UP;
`ifdef KEY_ACCEL_EN
            rep_cnt <= '0;
            fast    <= 1'b0;
`endif
        end else begin
            move_en <= 1'b0;
            if (!bus.en_i) begin
                state <= KEY_ST_IDLE;
                timer <= '0;
            end else begin
                case (state)
                    KEY_ST_IDLE: begin
                        if (any_key) state <= KEY_ST_FIRST;
                    end
                    KEY_ST_FIRST: begin
                        move_en <= 1'b1;
                        cur_dir <= sel_dir;
                        direct  <= sel_dir;
                        timer   <= '0;
                        state   <= KEY_ST_HOLD;
                    end
                    KEY_ST_HOLD: begin
                        if (!any_key) begin
                            state <= KEY_ST_IDLE;
                            timer <= '0;
                        end else if (sel_dir != cur_dir) begin
                            state <= KEY_ST_FIRST;
                        end else if (timer == HOLD_LAST) begin
                            // Prime the period timer so the first repeat fires on
                            // the next cycle: press-to-repeat gap is HOLD_DELAY+1.
                            state <= KEY_ST_REPEAT;
                            timer <= REP_LAST;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    KEY_ST_REPEAT: begin
                        if (!any_key) begin
                            state <= KEY_ST_IDLE;
                            timer <= '0;
                        end else if (sel_dir != cur_dir) begin
                            state <= KEY_ST_FIRST;
                        end else if (timer == rep_last) begin
                            move_en <= 1'b1;
                            timer   <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: state <= KEY_ST_IDLE;
                endcase
            end
`ifdef KEY_ACCEL_EN
            // The short period applies from the gap after the pulse that
            // finds the count already saturated.
            if (!rep_keep) begin
                rep_cnt <= '0;
                fast    <= 1'b0;
            end else if (timer == rep_last) begin
                if (rep_cnt == RCNT_SAT) fast <= 1'b1;
                else                     rep_cnt <= rep_cnt + RW'(1);
            end
`endif
        end
    end

    assign bus.move_en_o = move_en;
    assign bus.direct_o  = direct;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Scenario bench for key_move_ctrl with short timing; expected move pulses
// (edge number + direction) are queued as keys are driven and checked as they appear.
module tb_key_move_ctrl;
    import key_move_ctrl_pkg::*;

    localparam int DB = 4;
    localparam int HD = 10;
    localparam int RP = 5;
    localparam int AA = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    key_move_ctrl_if kif ();

    key_move_ctrl #(
        .DEBOUNCE_CYCLES(DB), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP), .ACCEL_AFTER(AA)
    ) dut (
        .clk_run (clk),
        .rst     (rst),
        .bus     (kif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        dir_e dir;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Advance to the next falling edge and score any move pulse against the queue.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (kif.move_en_o) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL pulse_unexpected: got pulse at edge %0d dir %0d, required no pulse", cyc, kif.direct_o);
                end else begin
                    e = q[0];
                    if (e.cyc != cyc || e.dir !== kif.direct_o) begin
                        n_err++;
                        $display("FAIL pulse: got edge %0d dir %0d, required edge %0d dir %0d", cyc, kif.direct_o, e.cyc, e.dir);
                        if (e.cyc <= cyc) void'(q.pop_front());
                    end else begin
                        void'(q.pop_front());
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL pulse_missing: got no pulse at edge %0d, required pulse dir %0d", cyc, q[0].dir);
                void'(q.pop_front());
            end
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    // First pulse, hold gap, then repeat gaps, for every pulse edge <= last.
    task automatic push_train(input int first, input dir_e d, input int last);
        int t;
        int k;
        exp_t e;
        e.dir = d;
        e.cyc = first;
        q.push_back(e);
        t = first + HD + 1;
        k = 1;
        while (t <= last) begin
            e.cyc = t;
            q.push_back(e);
`ifdef KEY_ACCEL_EN
            t += (k <= AA) ? RP : (RP >> 1);
`else
            t += RP;
`endif
            k++;
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_cmp++;
        if (kif.move_en_o !== 1'b0) begin
            n_err++; $display("FAIL reset_move_en: got %b, required 0", kif.move_en_o);
        end
        n_cmp++;
        if (kif.direct_o !== DIR_UP) begin
            n_err++; $display("FAIL reset_direct: got %0d, required %0d", kif.direct_o, DIR_UP);
        end
        rst = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_glitch();
        kif.key_up_i = 1'b1;
        repeat (3) step();
        kif.key_up_i = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (kif.direct_o !== DIR_UP) begin
            n_err++; $display("FAIL glitch_direct: got %0d, required %0d", kif.direct_o, DIR_UP);
        end
    endtask

    task automatic test_hold_repeat();
        int c = cyc;
        int r = c + 40;
        kif.key_left_i = 1'b1;
        push_train(c + 8, DIR_LEFT, r + 6);
        wait_until(r);
        kif.key_left_i = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (kif.direct_o !== DIR_LEFT) begin
            n_err++; $display("FAIL hold_direct_holds: got %0d, required %0d", kif.direct_o, DIR_LEFT);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL hold_drain: got %0d pending, required 0", q.size());
        end
    endtask

    task automatic test_dir_change();
        int c = cyc;
        int u = c + 21;
        int r = u + 30;
        kif.key_right_i = 1'b1;
        push_train(c + 8, DIR_RIGHT, u + 6);
        wait_until(u);
        kif.key_up_i = 1'b1;
        push_train(u + 8, DIR_UP, r + 6);
        wait_until(r);
        kif.key_up_i    = 1'b0;
        kif.key_right_i = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL dirchg_drain: got %0d pending, required 0", q.size());
        end
    endtask

    task automatic test_enable();
        int c = cyc;
        int r = c + 75;
        kif.key_down_i = 1'b1;
        push_train(c + 8, DIR_DOWN, c + 25);
        wait_until(c + 25);
        kif.en_i = 1'b0;
        wait_until(c + 45);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL en_low_drain: got %0d pending, required 0", q.size());
        end
        kif.en_i = 1'b1;
        push_train(c + 47, DIR_DOWN, r + 6);
        wait_until(r);
        kif.key_down_i = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL enable_drain: got %0d pending, required 0", q.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        int c = cyc;
        int s;
        int r;
        kif.key_down_i = 1'b1;
        push_train(c + 8, DIR_DOWN, c + 12);
        wait_until(c + 12);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (kif.move_en_o !== 1'b0) begin
            n_err++; $display("FAIL midrst_move_en: got %b, required 0", kif.move_en_o);
        end
        n_cmp++;
        if (kif.direct_o !== DIR_UP) begin
            n_err++; $display("FAIL midrst_direct: got %0d, required %0d", kif.direct_o, DIR_UP);
        end
        repeat (3) step();
        rst = 1'b0;
        s = cyc;
        r = s + 30;
        push_train(s + 8, DIR_DOWN, r + 6);
        wait_until(r);
        kif.key_down_i = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL midrst_drain: got %0d pending, required 0", q.size());
        end
    endtask

    task automatic test_accel();
        int c = cyc;
        int r = c + 45;
        kif.key_right_i = 1'b1;
        push_train(c + 8, DIR_RIGHT, r + 6);
        wait_until(r);
        kif.key_right_i = 1'b0;
        repeat (15) step();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL accel_drain: got %0d pending, required 0", q.size());
        end
        n_cmp++;
        if (kif.direct_o !== DIR_RIGHT) begin
            n_err++; $display("FAIL accel_direct: got %0d, required %0d", kif.direct_o, DIR_RIGHT);
        end
    endtask

    initial begin
        kif.en_i        = 1'b1;
        kif.key_up_i    = 1'b0;
        kif.key_down_i  = 1'b0;
        kif.key_left_i  = 1'b0;
        kif.key_right_i = 1'b0;
        test_reset();
        test_glitch();
        test_hold_repeat();
        test_dir_change();
        test_enable();
        test_reset_mid_hold();
        test_accel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
